// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
//   Shared VGA timing constants for the draw chain (1024x768 @ 60 Hz, 65 MHz
//   pixel clock) and a small window-decode helper.
//   No ports: imported with "import vga_pkg::*;".
// ---------------------------------------------------------------------------
package vga_pkg;

    localparam int unsigned HOR_PIXELS = 1024;
    localparam int unsigned VER_PIXELS = 768;

    localparam int unsigned H_FP_CLK   = 24;
    localparam int unsigned H_SYNC_CLK = 136;
    localparam int unsigned H_BP_CLK   = 160;

    localparam int unsigned V_FP_LINES   = 3;
    localparam int unsigned V_SYNC_LINES = 6;
    localparam int unsigned V_BP_LINES   = 29;

    localparam int unsigned H_TOTAL = HOR_PIXELS + H_FP_CLK + H_SYNC_CLK + H_BP_CLK;
    localparam int unsigned V_TOTAL = VER_PIXELS + V_FP_LINES + V_SYNC_LINES + V_BP_LINES;

    // Counter width shared by hcount/vcount.
    localparam int unsigned CNT_W   = 11;
    localparam int unsigned CNT_MAX = 2048;

    // True when val lies in [lo, lo+len). Done in 32 bits so an end bound of
    // exactly 2048 does not wrap an 11-bit compare.
    function automatic logic in_window(input int unsigned val,
                                       input int unsigned lo,
                                       input int unsigned len);
        return (val >= lo) && (val < (lo + len));
    endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// ---------------------------------------------------------------------------
// vga_axis_cnt
//   Modulo-TOTAL up counter for one VGA axis.
//   Ports:
//     clk   - pixel clock
//     rst_n - asynchronous active-low reset (counter -> 0)
//     en    - advance the counter this cycle
//     cnt   - current count (registered)
//     nxt   - value the counter takes at the next edge
//     tc    - terminal count: enabled and at TOTAL-1, i.e. wrapping now
// ---------------------------------------------------------------------------
module vga_axis_cnt
    import vga_pkg::*;
#(
    parameter int unsigned TOTAL = H_TOTAL,
    parameter int unsigned WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] cnt,
    output logic [WIDTH-1:0] nxt,
    output logic             tc
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(TOTAL - 1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        tc    = en && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (tc) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign nxt = cnt_d;

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Source of the VGA timing bundle for the draw chain: free-running pixel
//   counters, registered sync/blank decodes, start-of-frame pulse and a
//   completed-frame counter.
//   Ports:
//     clk       - pixel clock (65 MHz)
//     rst_n     - asynchronous active-low reset
//     hcount    - horizontal pixel position
//     vcount    - vertical line position
//     hsync     - horizontal sync, SYNC_ACTIVE when asserted
//     vsync     - vertical sync, SYNC_ACTIVE when asserted
//     hblnk     - horizontal blanking (hcount >= H_ACTIVE)
//     vblnk     - vertical blanking (vcount >= V_ACTIVE)
//     sof       - one-cycle pulse while pixel (0,0) is presented after a wrap
//     frame_cnt - completed-frame count, 16-bit wrapping
// ---------------------------------------------------------------------------
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = HOR_PIXELS,
    parameter int unsigned H_FP        = H_FP_CLK,
    parameter int unsigned H_SYNC      = H_SYNC_CLK,
    parameter int unsigned H_BP        = H_BP_CLK,
    parameter int unsigned V_ACTIVE    = VER_PIXELS,
    parameter int unsigned V_FP        = V_FP_LINES,
    parameter int unsigned V_SYNC      = V_SYNC_LINES,
    parameter int unsigned V_BP        = V_BP_LINES,
    parameter logic        SYNC_ACTIVE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [10:0] hcount,
    output logic [10:0] vcount,
    output logic        hsync,
    output logic        vsync,
    output logic        hblnk,
    output logic        vblnk,
    output logic        sof,
    output logic [15:0] frame_cnt
);

    localparam int unsigned HTOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned VTOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (HTOT > CNT_MAX) begin : gen_htot_check
        $error("vga_timing_gen: horizontal total exceeds 11-bit counter range");
    end
    if (VTOT > CNT_MAX) begin : gen_vtot_check
        $error("vga_timing_gen: vertical total exceeds 11-bit counter range");
    end

    logic [10:0] h_cnt;
    logic [10:0] h_nxt;
    logic        h_tc;
    logic [10:0] v_cnt;
    logic [10:0] v_nxt;
    logic        v_tc;

    vga_axis_cnt #(
        .TOTAL (HTOT),
        .WIDTH (CNT_W)
    ) u_hcnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .cnt   (h_cnt),
        .nxt   (h_nxt),
        .tc    (h_tc)
    );

    // Lines advance only on the horizontal wrap, so v_tc already implies the
    // frame wrap (both counters return to 0 on this edge).
    vga_axis_cnt #(
        .TOTAL (VTOT),
        .WIDTH (CNT_W)
    ) u_vcnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (h_tc),
        .cnt   (v_cnt),
        .nxt   (v_nxt),
        .tc    (v_tc)
    );

    logic        hsync_d, hsync_q;
    logic        vsync_d, vsync_q;
    logic        hblnk_d, hblnk_q;
    logic        vblnk_d, vblnk_q;
    logic        sof_d,   sof_q;
    logic [15:0] frame_cnt_d, frame_cnt_q;

    // Decode from the next counter values so the registered decodes land on
    // the same edge as the counters: zero skew across the bundle.
    always_comb begin
        hblnk_d = (32'(h_nxt) >= H_ACTIVE);
        vblnk_d = (32'(v_nxt) >= V_ACTIVE);
        hsync_d = in_window(32'(h_nxt), H_ACTIVE + H_FP, H_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_d = in_window(32'(v_nxt), V_ACTIVE + V_FP, V_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        sof_d   = v_tc;
        frame_cnt_d = frame_cnt_q;
        if (v_tc) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q     <= ~SYNC_ACTIVE;
            vsync_q     <= ~SYNC_ACTIVE;
            hblnk_q     <= 1'b0;
            vblnk_q     <= 1'b0;
            sof_q       <= 1'b0;
            frame_cnt_q <= 16'd0;
        end else begin
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            hblnk_q     <= hblnk_d;
            vblnk_q     <= vblnk_d;
            sof_q       <= sof_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign hcount    = h_cnt;
    assign vcount    = v_cnt;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign hblnk     = hblnk_q;
    assign vblnk     = vblnk_q;
    assign sof       = sof_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//   Directed bench for vga_timing_gen using a shrunken timing so whole frames
//   fit in a short run: H = 16+2+4+3 = 25 clocks, V = 8+1+2+2 = 13 lines,
//   325 clocks per frame. hsync for h 18..21, vsync for v 9..10.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int TH_A = 16, TH_FP = 2, TH_S = 4, TH_BP = 3;
    localparam int TV_A = 8,  TV_FP = 1, TV_S = 2, TV_BP = 2;
    localparam int FRAME = 325;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] hcount, vcount;
    logic        hsync, vsync, hblnk, vblnk, sof;
    logic [15:0] frame_cnt;

    int errors = 0;
    int checks = 0;
    bit align_en = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE    (TH_A),
        .H_FP        (TH_FP),
        .H_SYNC      (TH_S),
        .H_BP        (TH_BP),
        .V_ACTIVE    (TV_A),
        .V_FP        (TV_FP),
        .V_SYNC      (TV_S),
        .V_BP        (TV_BP),
        .SYNC_ACTIVE (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hcount    (hcount),
        .vcount    (vcount),
        .hsync     (hsync),
        .vsync     (vsync),
        .hblnk     (hblnk),
        .vblnk     (vblnk),
        .sof       (sof),
        .frame_cnt (frame_cnt)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Every cycle: decodes must match the hcount/vcount presented alongside.
    always @(negedge clk) begin
        if (align_en && rst_n) begin
            chk("align_hblnk", int'(hblnk), int'(int'(hcount) >= TH_A));
            chk("align_vblnk", int'(vblnk), int'(int'(vcount) >= TV_A));
            chk("align_hsync", int'(hsync),
                int'(int'(hcount) >= TH_A + TH_FP && int'(hcount) < TH_A + TH_FP + TH_S));
            chk("align_vsync", int'(vsync),
                int'(int'(vcount) >= TV_A + TV_FP && int'(vcount) < TV_A + TV_FP + TV_S));
        end
    end

    typedef struct {
        int   k;     // posedges since reset release
        int   h;
        int   v;
        logic hs;
        logic vs;
        logic hb;
        logic vb;
        logic sf;
        int   fc;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs[NVEC];
    int   k;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_hcount"}, int'(hcount), 0);
        chk({tag, "_vcount"}, int'(vcount), 0);
        chk({tag, "_hsync"}, int'(hsync), 0);
        chk({tag, "_vsync"}, int'(vsync), 0);
        chk({tag, "_hblnk"}, int'(hblnk), 0);
        chk({tag, "_vblnk"}, int'(vblnk), 0);
        chk({tag, "_sof"}, int'(sof), 0);
        chk({tag, "_frame_cnt"}, int'(frame_cnt), 0);
    endtask

    task automatic wait_sof(input int bound, output int n, output bit found);
        n = 0;
        found = 1'b0;
        while (!found && n < bound) begin
            step();
            n++;
            if (sof) found = 1'b1;
        end
    endtask

    initial begin
        int  n;
        bit  found;

        //            k    h   v  hs vs hb vb sf fc
        vecs[0]  = '{   0,  0,  0, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{   1,  1,  0, 0, 0, 0, 0, 0, 0};
        vecs[2]  = '{  15, 15,  0, 0, 0, 0, 0, 0, 0};
        vecs[3]  = '{  16, 16,  0, 0, 0, 1, 0, 0, 0};
        vecs[4]  = '{  17, 17,  0, 0, 0, 1, 0, 0, 0};
        vecs[5]  = '{  18, 18,  0, 1, 0, 1, 0, 0, 0};
        vecs[6]  = '{  21, 21,  0, 1, 0, 1, 0, 0, 0};
        vecs[7]  = '{  22, 22,  0, 0, 0, 1, 0, 0, 0};
        vecs[8]  = '{  24, 24,  0, 0, 0, 1, 0, 0, 0};
        vecs[9]  = '{  25,  0,  1, 0, 0, 0, 0, 0, 0};
        vecs[10] = '{ 199, 24,  7, 0, 0, 1, 0, 0, 0};
        vecs[11] = '{ 200,  0,  8, 0, 0, 0, 1, 0, 0};
        vecs[12] = '{ 225,  0,  9, 0, 1, 0, 1, 0, 0};
        vecs[13] = '{ 255,  5, 10, 0, 1, 0, 1, 0, 0};
        vecs[14] = '{ 275,  0, 11, 0, 0, 0, 1, 0, 0};
        vecs[15] = '{ 324, 24, 12, 0, 0, 1, 1, 0, 0};
        vecs[16] = '{ 325,  0,  0, 0, 0, 0, 0, 1, 1};
        vecs[17] = '{ 326,  1,  0, 0, 0, 0, 0, 0, 1};
        vecs[18] = '{ 650,  0,  0, 0, 0, 0, 0, 1, 2};
        vecs[19] = '{ 975,  0,  0, 0, 0, 0, 0, 1, 3};

        // Reset held for 10 clocks; async assert means outputs are already reset.
        repeat (10) @(negedge clk);
        chk_reset_vals("in_reset");
        rst_n = 1'b1;
        align_en = 1'b1;
        k = 0;

        for (int i = 0; i < NVEC; i++) begin
            while (k < vecs[i].k) begin
                step();
                k++;
            end
            chk($sformatf("vec%0d_hcount", i), int'(hcount), vecs[i].h);
            chk($sformatf("vec%0d_vcount", i), int'(vcount), vecs[i].v);
            chk($sformatf("vec%0d_hsync", i), int'(hsync), int'(vecs[i].hs));
            chk($sformatf("vec%0d_vsync", i), int'(vsync), int'(vecs[i].vs));
            chk($sformatf("vec%0d_hblnk", i), int'(hblnk), int'(vecs[i].hb));
            chk($sformatf("vec%0d_vblnk", i), int'(vblnk), int'(vecs[i].vb));
            chk($sformatf("vec%0d_sof", i), int'(sof), int'(vecs[i].sf));
            chk($sformatf("vec%0d_frame_cnt", i), int'(frame_cnt), vecs[i].fc);
        end

        // Mid-frame async reset at pixel (10,5) of the fourth frame.
        while (k < 3 * FRAME + 5 * 25 + 10) begin
            step();
            k++;
        end
        chk("pre_reset_hcount", int'(hcount), 10);
        chk("pre_reset_vcount", int'(vcount), 5);
        chk("pre_reset_frame_cnt", int'(frame_cnt), 3);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("async_reset");
        repeat (3) @(negedge clk);
        chk_reset_vals("held_reset");
        rst_n = 1'b1;
        wait_sof(2 * FRAME, n, found);
        chk("restart_sof_seen", int'(found), 1);
        chk("restart_sof_latency", n, FRAME);
        chk("restart_frame_cnt", int'(frame_cnt), 1);
        chk("restart_sof_hcount", int'(hcount), 0);
        chk("restart_sof_vcount", int'(vcount), 0);
        step();
        chk("restart_sof_width", int'(sof), 0);

        // Frame counter wrap: deposit 0xFFFF away from the sof edge.
        repeat (40) step();
        force dut.frame_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt_q;
        step();
        chk("deposit_frame_cnt", int'(frame_cnt), 32'hFFFF);
        wait_sof(2 * FRAME, n, found);
        chk("wrap_sof_seen", int'(found), 1);
        chk("wrap_frame_cnt", int'(frame_cnt), 0);
        step();
        chk("wrap_frame_cnt_hold", int'(frame_cnt), 0);

        align_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Source end of the vga_tim interface: produces hcount/vcount, hsync/vsync and hblnk/vblnk for the whole draw chain.
- Every drawing stage (backgrounds, win screens, sprites) consumes these signals and registers them one stage later.
- The block is free-running pixel-clock counters with registered decoded outputs, plus a start-of-frame pulse and a frame counter for game logic.

Parameters:
- H_ACTIVE, 1024, visible pixels per line (equals HOR_PIXELS)
- H_FP, 24, horizontal front porch in clocks
- H_SYNC, 136, hsync width in clocks
- H_BP, 160, horizontal back porch in clocks
- V_ACTIVE, 768, visible lines (equals VER_PIXELS)
- V_FP, 3, vertical front porch in lines
- V_SYNC, 6, vsync width in lines
- V_BP, 29, vertical back porch in lines
- SYNC_ACTIVE, 1'b1, asserted level of hsync/vsync

Ports:
- clk, in, 1: pixel clock, 65 MHz
- rst_n, in, 1: asynchronous reset, active-low
- tim_out, vga_tim.out, bundle: hcount[10:0], vcount[10:0], hsync, vsync, hblnk, vblnk
- sof, out, 1: one-cycle pulse while pixel (0,0) is presented
- frame_cnt, out, 16: completed-frame count

Behaviour:
- One clock only. The single reset is rst_n, asynchronous assert and synchronous-safe release; all flops reset on negedge rst_n.
- Reset values:
  - hcount = 0, vcount = 0
  - hblnk = 0, vblnk = 0
  - hsync = vsync = ~SYNC_ACTIVE
  - sof = 0, frame_cnt = 0
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1344); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (806).
- Horizontal counter:
  - increments every clock; at H_TOTAL-1 wraps to 0.
- Vertical counter:
  - increments only on the cycle the horizontal counter wraps; at V_TOTAL-1 (coinciding with the H wrap) wraps to 0.
- First rising edge after rst_n deasserts advances (0,0) to (1,0). Pixel (0,0) is presented during reset and then once per frame.
- Decodes are all registered and computed from the next counter values, so on every cycle all six interface outputs describe the same pixel (zero skew):
  - hblnk = (hcount >= H_ACTIVE)
  - vblnk = (vcount >= V_ACTIVE)
  - hsync active for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
  - vsync active for vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), for the full line width
- sof:
  - registered, high exactly on the cycle where outputs present (0,0) after a wrap.
  - Not asserted in the first cycle after reset: the first sof is at the first natural wrap.
- frame_cnt:
  - increments by 1 on the same clock edge that makes sof rise; 16-bit modulo, 0xFFFF -> 0x0000.
- Latency: one register between counter state and outputs; the counter and output stage are in lock-step, with no pipeline bubble.
- Reset mid-frame: all outputs return to reset values immediately (async). Counting restarts from (0,0) with no partial sof.
- Widths: 11-bit counters; H_TOTAL and V_TOTAL must be ≤ 2048 (elaboration-time assertion). Comparisons are unsigned.

Decomposition:
- vga_pkg:
  - keeps HOR_PIXELS and VER_PIXELS and gains the porch/sync constants, H_TOTAL and V_TOTAL.
  - parameter defaults reference these constants.
- Sub-module vga_axis_cnt:
  - parameterised modulo counter with enable input, terminal-count output and next-value output.
  - instantiated twice: horizontal with enable tied 1; vertical enabled by horizontal terminal count.
- Sync/blank decode and sof/frame_cnt stay in vga_timing_gen.

Test Plan:
- Reset release: hold rst_n=0 for 10 clk, release -> hcount=0, vcount=0, hsync=vsync=0, sof=0; next edge hcount=1, vcount=0.
- Line timing: free-run one line -> hblnk 0 for hcount 0..1023 and 1 for 1024..1343; hsync high for hcount 1048..1183 (136 clocks); hcount 1343 -> 0 while vcount 0 -> 1.
- Frame timing: free-run 1,083,264 clocks -> vblnk high for vcount 768..805; vsync high for vcount 771..776 (6 lines); sof pulses once with outputs (0,0) and frame_cnt=1.
- Alignment checker: every cycle, assert hblnk/hsync/vblnk/vsync equal the decode of the concurrently presented hcount/vcount; zero mismatches over 3 frames.
- Async reset mid-frame: drop rst_n at (500,300) between clock edges -> outputs reach reset values before the next edge; after release, the next sof comes 1,083,264 clocks after restart and frame_cnt restarts at 1.
- Counter wrap: force frame_cnt to 0xFFFF via hierarchical deposit, run to next sof -> frame_cnt=0x0000 in the same cycle sof=1.
